tx_sched_pend_tracker: RTL and testbench

Per-flow transmit-pending tracker and scheduler on the consumer side of the `sched_cmd_struct` command interface. Timeout, ACK-generation and send-buffer engines use this interface to set or clear `rt`/`ack`/`data` pending bits per flow. The block holds those bits in per-flow bit vectors. It round-robin arbitrates among flows with any bit pending and issues one flow at a time to the TX engine over a val/rdy handshake. Issued bits are cleared on handshake.

---
 rtl/tx_sched_pend_tracker.sv | 159 +++++++++++++++
 tb/tb_tx_sched_pend_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sched_pend_tracker.sv
// tx_sched_pend_tracker
//
// Per-flow transmit-pending tracker and round-robin scheduler. Producers
// (timeout, ACK generation, send buffer) set or clear rt/ack/data pending
// bits per flow through the sched_cmd_struct command port. The block keeps
// those bits in three per-flow vectors, picks one flow with anything pending
// and presents it to the TX engine with a val/rdy handshake. The bits carried
// in the issued snapshot are cleared when the engine accepts the flow.
//
// Ports:
//   clk                     clock
//   rst                     asynchronous active-high reset
//   src_tx_sched_cmd_val    command valid
//   src_tx_sched_cmd_data   command: flowid + NOP/SET/CLEAR for rt, ack, data
//   tx_sched_src_cmd_rdy    command ready (1 whenever out of reset)
//   tx_sched_tx_eng_val     issued flow valid
//   tx_sched_tx_eng_flowid  issued flow id
//   tx_sched_tx_eng_pend    snapshot of {rt, ack, data} for the issued flow
//   tx_eng_tx_sched_rdy     TX engine accepts the issued flow
//
// Build option:
//   TX_SCHED_RT_PRIO_EN     when defined, flows with rt pending are searched
//                           first; otherwise one round-robin over all flows.

localparam int MAX_TCP_FLOWS      = 8;
localparam int SCHED_CMD_FLOWID_W = 4;

typedef enum logic [1:0] {
    SCHED_NOP   = 2'd0,
    SCHED_SET   = 2'd1,
    SCHED_CLEAR = 2'd2
} sched_op_e;

typedef struct packed {
    logic [SCHED_CMD_FLOWID_W-1:0] flowid;
    sched_op_e                     rt_pend_set_clear;
    sched_op_e                     ack_pend_set_clear;
    sched_op_e                     data_pend_set_clear;
} sched_cmd_struct;

module tx_sched_pend_tracker #(
    parameter int NUM_FLOWS = MAX_TCP_FLOWS,
    parameter int FLOWID_W  = $clog2(NUM_FLOWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                src_tx_sched_cmd_val,
    input  sched_cmd_struct     src_tx_sched_cmd_data,
    output logic                tx_sched_src_cmd_rdy,
    output logic                tx_sched_tx_eng_val,
    output logic [FLOWID_W-1:0] tx_sched_tx_eng_flowid,
    output logic [2:0]          tx_sched_tx_eng_pend,
    input  logic                tx_eng_tx_sched_rdy
);

    typedef enum logic {ST_SELECT, ST_ISSUE} state_e;

    state_e                state;
    logic [NUM_FLOWS-1:0]  rt_pend, ack_pend, data_pend, any_pend;
    logic [NUM_FLOWS-1:0]  rt_nxt, ack_nxt, data_nxt;
    logic [FLOWID_W-1:0]   rr_ptr, rr_after, cmd_idx, pick_idx;
    logic [FLOWID_W:0]     pick;
    logic                  cmd_hit, handshake;

    // Rotated priority encode: first set bit at or after ptr, wrapping.
    // Returns {found, index}. Scanning downward lets the lowest offset win.
    function automatic logic [FLOWID_W:0] rr_find(input logic [NUM_FLOWS-1:0] vec,
                                                  input logic [FLOWID_W-1:0]  ptr);
        logic [FLOWID_W:0] res;
        int                idx;
        res = '0;
        for (int k = NUM_FLOWS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_FLOWS) idx = idx - NUM_FLOWS;
            if (vec[FLOWID_W'(idx)]) res = {1'b1, FLOWID_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic apply_op(input logic cur, input sched_op_e op);
        case (op)
            SCHED_SET:   return 1'b1;
            SCHED_CLEAR: return 1'b0;
            default:     return cur;
        endcase
    endfunction

    assign tx_sched_src_cmd_rdy = ~rst;
    assign any_pend  = rt_pend | ack_pend | data_pend;
    assign handshake = tx_sched_tx_eng_val & tx_eng_tx_sched_rdy;
    assign cmd_hit   = src_tx_sched_cmd_val &
                       (int'(src_tx_sched_cmd_data.flowid) < NUM_FLOWS);
    assign cmd_idx   = FLOWID_W'(src_tx_sched_cmd_data.flowid);
    assign rr_after  = (tx_sched_tx_eng_flowid == FLOWID_W'(NUM_FLOWS - 1)) ?
                       '0 : tx_sched_tx_eng_flowid + FLOWID_W'(1);
    assign pick_idx  = pick[FLOWID_W-1:0];

`ifdef TX_SCHED_RT_PRIO_EN
    always_comb begin
        pick = rr_find(rt_pend, rr_ptr);
        if (!pick[FLOWID_W]) pick = rr_find(any_pend, rr_ptr);
    end
`else
    assign pick = rr_find(any_pend, rr_ptr);
`endif

    // Handshake clear is applied before the same-cycle command, so a SET
    // to the flow being retired survives and a CLEAR still clears.
    always_comb begin
        rt_nxt   = rt_pend;
        ack_nxt  = ack_pend;
        data_nxt = data_pend;
        if (handshake) begin
            if (tx_sched_tx_eng_pend[2]) rt_nxt[tx_sched_tx_eng_flowid]   = 1'b0;
            if (tx_sched_tx_eng_pend[1]) ack_nxt[tx_sched_tx_eng_flowid]  = 1'b0;
            if (tx_sched_tx_eng_pend[0]) data_nxt[tx_sched_tx_eng_flowid] = 1'b0;
        end
        if (cmd_hit) begin
            rt_nxt[cmd_idx]   = apply_op(rt_nxt[cmd_idx],   src_tx_sched_cmd_data.rt_pend_set_clear);
            ack_nxt[cmd_idx]  = apply_op(ack_nxt[cmd_idx],  src_tx_sched_cmd_data.ack_pend_set_clear);
            data_nxt[cmd_idx] = apply_op(data_nxt[cmd_idx], src_tx_sched_cmd_data.data_pend_set_clear);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= ST_SELECT;
            rt_pend                <= '0;
            ack_pend               <= '0;
            data_pend              <= '0;
            rr_ptr                 <= '0;
            tx_sched_tx_eng_val    <= 1'b0;
            tx_sched_tx_eng_flowid <= '0;
            tx_sched_tx_eng_pend   <= '0;
        end else begin
            rt_pend   <= rt_nxt;
            ack_pend  <= ack_nxt;
            data_pend <= data_nxt;
            if (state == ST_SELECT) begin
                // Snapshot uses the vectors as they stand; a command landing
                // in this same cycle is seen on the next selection.
                if (pick[FLOWID_W]) begin
                    tx_sched_tx_eng_flowid <= pick_idx;
                    tx_sched_tx_eng_pend   <= {rt_pend[pick_idx], ack_pend[pick_idx],
                                               data_pend[pick_idx]};
                    tx_sched_tx_eng_val    <= 1'b1;
                    state                  <= ST_ISSUE;
                end
            end else begin
                if (handshake) begin
                    tx_sched_tx_eng_val <= 1'b0;
                    rr_ptr              <= rr_after;
                    state               <= ST_SELECT;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_sched_pend_tracker.sv
// Testbench for tx_sched_pend_tracker: directed scenarios followed by
// randomized commands and back-pressure, checked every cycle against a
// flow-level reference model of the pending-bit scheduler.
module tb_tx_sched_pend_tracker;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int OP_NOP = 0;
    localparam int OP_SET = 1;
    localparam int OP_CLR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_val = 1'b0;
    logic [9:0]    cmd_data = '0;
    logic          cmd_rdy;
    logic          tx_val;
    logic [FW-1:0] tx_flowid;
    logic [2:0]    tx_pend;
    logic          eng_rdy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int issued[$];

    // Reference model: per-flow pending flags plus the flow currently offered.
    bit m_rt[NF];
    bit m_ack[NF];
    bit m_dat[NF];
    int m_ptr;
    bit m_busy;
    int m_flow;
    int m_pend;

    tx_sched_pend_tracker #(.NUM_FLOWS(NF), .FLOWID_W(FW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .src_tx_sched_cmd_val   (cmd_val),
        .src_tx_sched_cmd_data  (cmd_data),
        .tx_sched_src_cmd_rdy   (cmd_rdy),
        .tx_sched_tx_eng_val    (tx_val),
        .tx_sched_tx_eng_flowid (tx_flowid),
        .tx_sched_tx_eng_pend   (tx_pend),
        .tx_eng_tx_sched_rdy    (eng_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NF; i++) begin
            m_rt[i] = 0; m_ack[i] = 0; m_dat[i] = 0;
        end
        m_ptr = 0; m_busy = 0; m_flow = 0; m_pend = 0;
    endfunction

    function automatic bit m_op(input bit cur, input int op);
        if (op == OP_SET) return 1'b1;
        if (op == OP_CLR) return 1'b0;
        return cur;
    endfunction

    function automatic bit m_any(input int f);
        return m_rt[f] | m_ack[f] | m_dat[f];
    endfunction

    // One clock edge of the scheduler's rules.
    function automatic void m_step(input bit cv, input int fid, input int r, input int a,
                                   input int d, input bit rd);
        int f;
        if (m_busy) begin
            if (rd) begin
                if (m_pend[2]) m_rt[m_flow]  = 0;
                if (m_pend[1]) m_ack[m_flow] = 0;
                if (m_pend[0]) m_dat[m_flow] = 0;
                m_ptr  = (m_flow + 1) % NF;
                m_busy = 0;
            end
        end else begin
            f = -1;
`ifdef TX_SCHED_RT_PRIO_EN
            for (int k = 0; k < NF; k++)
                if (f < 0 && m_rt[(m_ptr + k) % NF]) f = (m_ptr + k) % NF;
`endif
            for (int k = 0; k < NF; k++)
                if (f < 0 && m_any((m_ptr + k) % NF)) f = (m_ptr + k) % NF;
            if (f >= 0) begin
                m_busy = 1;
                m_flow = f;
                m_pend = 4 * int'(m_rt[f]) + 2 * int'(m_ack[f]) + int'(m_dat[f]);
            end
        end
        if (cv && fid < NF) begin
            m_rt[fid]  = m_op(m_rt[fid], r);
            m_ack[fid] = m_op(m_ack[fid], a);
            m_dat[fid] = m_op(m_dat[fid], d);
        end
    endfunction

    // Called at a negedge: drive inputs, advance model, clock, compare.
    task automatic step(input bit cv, input int fid, input int r, input int a,
                        input int d, input bit rd);
        cmd_val  = cv;
        cmd_data = {fid[3:0], r[1:0], a[1:0], d[1:0]};
        eng_rdy  = rd;
        if (tx_val && rd) issued.push_back(int'(tx_flowid));
        m_step(cv, fid, r, a, d, rd);
        @(posedge clk);
        @(negedge clk);
        chk_eq("val",     tx_val,    m_busy);
        chk_eq("flowid",  tx_flowid, m_flow);
        chk_eq("pend",    tx_pend,   m_pend);
        chk_eq("cmd_rdy", cmd_rdy,   1);
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(0, 0, OP_NOP, OP_NOP, OP_NOP, rd);
    endtask

    // Called at a negedge: reset asserted between edges, checked immediately.
    task automatic do_reset();
        #2;
        rst     = 1'b1;
        cmd_val = 1'b0;
        eng_rdy = 1'b0;
        #1;
        chk_eq("rst_val",     tx_val,    0);
        chk_eq("rst_flowid",  tx_flowid, 0);
        chk_eq("rst_pend",    tx_pend,   0);
        chk_eq("rst_cmd_rdy", cmd_rdy,   0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        issued.delete();
    endtask

    task automatic chk_issued(input string tag, input int n, input int e0, input int e1,
                              input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk_eq({tag, "_count"}, issued.size(), n);
        for (int i = 0; i < n; i++)
            chk_eq(tag, (i < issued.size()) ? issued[i] : -1, e[i]);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        do_reset();

        // Basic issue: SET ack on flow 3, valid two cycles later.
        step(1, 3, OP_NOP, OP_SET, OP_NOP, 0);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
        chk_eq("basic_val", tx_val, 1);
        chk_eq("basic_flowid", tx_flowid, 3);
        chk_eq("basic_pend", tx_pend, 3'b010);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 1);
        chk_eq("basic_val_drop", tx_val, 0);
        idle(3, 1);

        // Round-robin fairness with re-set of flow 0 after its issue.
        do_reset();
        step(1, 0, OP_NOP, OP_NOP, OP_SET, 1);
        step(1, 2, OP_NOP, OP_NOP, OP_SET, 1);
        step(1, 5, OP_NOP, OP_NOP, OP_SET, 1);
        step(1, 0, OP_NOP, OP_NOP, OP_SET, 1);
        idle(10, 1);
        chk_issued("rr_order", 4, 0, 2, 5, 0);

        // Back-pressure: outputs frozen, rt SET during stall not reflected.
        do_reset();
        step(1, 1, OP_NOP, OP_NOP, OP_SET, 0);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) step(1, 1, OP_SET, OP_NOP, OP_NOP, 0);
            else        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
            chk_eq("stall_val", tx_val, 1);
            chk_eq("stall_flowid", tx_flowid, 1);
            chk_eq("stall_pend", tx_pend, 3'b001);
        end
        idle(6, 1);

        // Same-cycle collision: SET survives the clear, CLEAR does not.
        do_reset();
        step(1, 4, OP_NOP, OP_NOP, OP_SET, 0);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
        chk_eq("coll_flowid", tx_flowid, 4);
        step(1, 4, OP_NOP, OP_NOP, OP_SET, 1);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
        chk_eq("coll_reissue_val", tx_val, 1);
        chk_eq("coll_reissue_flowid", tx_flowid, 4);
        step(1, 4, OP_NOP, OP_NOP, OP_CLR, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, OP_NOP, OP_NOP, OP_NOP, 1);
            chk_eq("coll_no_reissue", tx_val, 0);
        end

        // Wrap-around: rr_ptr lands on NF-1 with NF-1 and 0 pending.
        do_reset();
        step(1, NF - 2, OP_NOP, OP_NOP, OP_SET, 0);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
        step(1, 0, OP_NOP, OP_NOP, OP_SET, 0);
        step(1, NF - 1, OP_NOP, OP_NOP, OP_SET, 0);
        idle(8, 1);
        chk_issued("wrap_order", 3, NF - 2, NF - 1, 0, 0);

        // rt priority: data on 1, rt on 6, rr_ptr returns to 0.
        do_reset();
        step(1, NF - 1, OP_NOP, OP_NOP, OP_SET, 0);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
        step(1, 1, OP_NOP, OP_NOP, OP_SET, 0);
        step(1, 6, OP_SET, OP_NOP, OP_NOP, 0);
        idle(8, 1);
`ifdef TX_SCHED_RT_PRIO_EN
        chk_issued("prio_order", 3, NF - 1, 6, 1, 0);
`else
        chk_issued("prio_order", 3, NF - 1, 1, 6, 0);
`endif

        // Reset in the middle of an issue drops everything.
        do_reset();
        step(1, 2, OP_NOP, OP_NOP, OP_SET, 0);
        step(0, 0, OP_NOP, OP_NOP, OP_NOP, 0);
        chk_eq("midrst_pre_val", tx_val, 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, OP_NOP, OP_NOP, OP_NOP, 1);
            chk_eq("midrst_post_val", tx_val, 0);
        end

        // Randomized traffic, including out-of-range flow ids.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, NF + 3),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 99) < 65);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
